// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller: access size codes,
// FSM state encoding and the alignment rule used by the request check.
package mem_access_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_ILL  = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2,
      RESP   = 2'd3
   } state_e;

   // Illegal size counts as misaligned so one test covers both error causes.
   function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = |addr_lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between the execute stage (master) and the
// memory access controller (slave).
interface mem_access_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Little-endian lane steering: extracts and extends sub-word loads, and merges
// sub-word store data into the word read back from memory.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  size_e       size,
   input  logic        is_signed,
   input  logic [31:0] rdata,
   input  logic [15:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
      load_data = rdata;
      merged    = rdata;
      byte_lane = rdata[{addr_lo, 3'b000} +: 8];
      half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: begin
            load_data                       = {{24{is_signed & byte_lane[7]}}, byte_lane};
            merged[{addr_lo, 3'b000} +: 8]  = wdata[7:0];
         end
         SZ_HALF: begin
            load_data                          = {{16{is_signed & half_lane[15]}}, half_lane};
            merged[{addr_lo[1], 4'b0000} +: 16] = wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the data-memory port: one load/store in flight, sub-word
// stores done as read-modify-write, bad requests answered with an error.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int WORD_AW = 10
) (
   input  logic               clk,
   input  logic               reset,
   mem_access_ctrl_if.slave   bus,
   output logic               mem_we,
   output logic [31:0]        mem_addr,
   output logic [31:0]        mem_wdata,
   input  logic [31:0]        mem_rdata
);

   state_e             state;
   logic               wr_q;
   logic               signed_q;
   size_e              size_q;
   logic [1:0]         addr_lo_q;
   logic [15:0]        wdata_q;
   logic               mem_we_q;
   logic               resp_valid_q;
   logic               resp_err_q;
   logic [31:0]        resp_rdata_q;

   size_e              req_size;
   logic               req_err;
   logic               req_word_store;
   logic [31:0]        load_data;
   logic [31:0]        merged;

   assign req_size       = size_e'(bus.req_size);
   assign req_err        = is_misaligned(req_size, bus.req_addr[1:0]) ||
                           (|bus.req_addr[31:WORD_AW+2]);
   assign req_word_store = bus.req_write && (req_size == SZ_WORD);

   mem_lane_align u_align (
      .addr_lo   (addr_lo_q),
      .size      (size_q),
      .is_signed (signed_q),
      .rdata     (mem_rdata),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
      if (reset) begin
         state        <= IDLE;
         wr_q         <= 1'b0;
         signed_q     <= 1'b0;
         size_q       <= SZ_BYTE;
         addr_lo_q    <= 2'b00;
         wdata_q      <= '0;
         mem_we_q     <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  wr_q         <= bus.req_write;
                  signed_q     <= bus.req_signed;
                  size_q       <= req_size;
                  addr_lo_q    <= bus.req_addr[1:0];
                  wdata_q      <= bus.req_wdata[15:0];
                  resp_rdata_q <= '0;
                  resp_err_q   <= req_err;
                  if (req_err) begin
                     state        <= RESP;
                     resp_valid_q <= 1'b1;
                  end else begin
                     state     <= ACCESS;
                     mem_addr  <= {{(32-WORD_AW){1'b0}}, bus.req_addr[WORD_AW+1:2]};
                     mem_we_q  <= req_word_store;
                     mem_wdata <= req_word_store ? bus.req_wdata : '0;
                  end
               end
            end
            ACCESS: begin
               if (wr_q && (size_q != SZ_WORD)) begin
                  // Read half of the read-modify-write; the merge lands next cycle.
                  state     <= WRITE;
                  mem_we_q  <= 1'b1;
                  mem_wdata <= merged;
               end else begin
                  state        <= RESP;
                  mem_we_q     <= 1'b0;
                  mem_addr     <= '0;
                  mem_wdata    <= '0;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= wr_q ? '0 : load_data;
               end
            end
            WRITE: begin
               state        <= RESP;
               mem_we_q     <= 1'b0;
               mem_addr     <= '0;
               mem_wdata    <= '0;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= '0;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state        <= IDLE;
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Masking with reset keeps a pending write from landing on the reset edge.
   assign mem_we         = mem_we_q & ~reset;
   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Pairs mem_access_ctrl with a 1024x32 data memory model; directed requests
// push expected responses to a scoreboard that a separate monitor drains.
module tb_mem_access_ctrl;
   import mem_access_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_access_ctrl_if bus();

   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] mem [1024] = '{default: 32'h0};

   mem_access_ctrl #(.WORD_AW(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
   assign mem_rdata = mem[mem_addr[9:0]];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          we_cnt = 0;
   bit          in_resp = 1'b0;
   logic [31:0] held_rdata;
   logic        held_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: response first seen is compared with the scoreboard head, then held values checked.
   always @(negedge clk) begin
      if (mem_we) we_cnt++;
      if (reset) begin
         in_resp = 1'b0;
      end else begin
         if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
         if (!bus.resp_valid) begin
            in_resp = 1'b0;
         end else if (!in_resp) begin
            in_resp    = 1'b1;
            held_rdata = bus.resp_rdata;
            held_err   = bus.resp_err;
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_resp: got rdata %h err %b with no request outstanding", bus.resp_rdata, bus.resp_err);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("resp_rdata", bus.resp_rdata, e.rdata);
               check("resp_err", 32'(bus.resp_err), 32'(e.err));
               check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            end
         end else begin
            check("held_rdata", bus.resp_rdata, held_rdata);
            check("held_err", 32'(bus.resp_err), 32'(held_err));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_err,
                        input int exp_lat);
      int n;
      exp_t e;
      n = 0;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.lat   = exp_lat;
      sb_q.push_back(e);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      forever begin
         @(negedge clk);
         if (bus.req_ready) break;
         n++;
         if (n > 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: req_ready stayed %b for addr %h", bus.req_ready, addr);
            break;
         end
      end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (sb_q.size() == 0 && bus.req_ready && !bus.resp_valid) break;
         n++;
         if (n > 50) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: %0d responses outstanding, req_ready %b", sb_q.size(), bus.req_ready);
            sb_q.delete();
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic xact(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_err,
                       input int exp_lat);
      issue(wr, sz, sg, addr, wdata, exp_rdata, exp_err, exp_lat);
      wait_done();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int we0;
      int n;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_resp_err", 32'(bus.resp_err), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Word store/load, then byte merge over it.
      xact(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
      xact(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
      xact(1, 2'd0, 0, 32'h11, 32'h00000080, 32'h0, 0, 3);
      check("mem_word4_after_byte", mem[4], 32'hDEAD80EF);
      xact(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0, 2);

      // Sub-word loads with both extensions.
      xact(0, 2'd0, 1, 32'h11, 32'h0, 32'hFFFFFF80, 0, 2);
      xact(0, 2'd0, 0, 32'h11, 32'h0, 32'h00000080, 0, 2);
      xact(0, 2'd1, 1, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 2);
      xact(0, 2'd1, 0, 32'h12, 32'h0, 32'h0000DEAD, 0, 2);
      xact(0, 2'd0, 1, 32'h10, 32'h0, 32'hFFFFFFEF, 0, 2);

      // Upper-half store ignores wdata[31:16]; top word of memory is in range.
      xact(1, 2'd1, 0, 32'h16, 32'h5555ABCD, 32'h0, 0, 3);
      xact(0, 2'd2, 0, 32'h14, 32'h0, 32'hABCD0000, 0, 2);
      xact(1, 2'd2, 0, 32'hFFC, 32'hCAFEF00D, 32'h0, 0, 2);
      xact(0, 2'd0, 0, 32'hFFF, 32'h0, 32'h000000CA, 0, 2);
      check("mem_top_word", mem[1023], 32'hCAFEF00D);

      // Error cases: one cycle, no memory write.
      we0 = we_cnt;
      xact(0, 2'd1, 0, 32'h13, 32'h0, 32'h0, 1, 1);
      xact(1, 2'd2, 0, 32'h12, 32'h12345678, 32'h0, 1, 1);
      xact(0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 1);
      xact(0, 2'd2, 0, 32'h1000, 32'h0, 32'h0, 1, 1);
      xact(1, 2'd0, 0, 32'h1000, 32'h000000FF, 32'h0, 1, 1);
      xact(1, 2'd3, 0, 32'h10, 32'h11111111, 32'h0, 1, 1);
      check("err_no_mem_we", 32'(we_cnt - we0), 32'd0);
      check("err_mem_word4", mem[4], 32'hDEAD80EF);
      check("err_mem_word0", mem[0], 32'h0);

      // Back-pressure: response held for five cycles.
      bus.resp_ready = 1'b0;
      issue(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0, 2);
      n = 0;
      while (!bus.resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("hold_req_ready", 32'(bus.req_ready), 32'd0);
         check("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
         check("hold_rdata_val", bus.resp_rdata, 32'hDEAD80EF);
      end
      @(posedge clk);
      #1 bus.resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("release_req_ready", 32'(bus.req_ready), 32'd1);
      check("release_resp_valid", 32'(bus.resp_valid), 32'd0);
      @(posedge clk);
      #1;

      // Reset while the merged byte is about to be written.
      xact(1, 2'd2, 0, 32'h20, 32'h11223344, 32'h0, 0, 2);
      issue(1, 2'd0, 0, 32'h21, 32'h000000AA, 32'h0, 0, 3);
      n = 0;
      forever begin
         @(negedge clk);
         if (mem_we) break;
         n++;
         if (n > 10) begin
            checks++;
            failures++;
            $display("FAIL write_phase_timeout: mem_we stayed %b", mem_we);
            break;
         end
      end
      #1 reset = 1'b1;
      sb_q.delete();
      #1 check("we_during_reset", 32'(mem_we), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort_mem_word8", mem[8], 32'h11223344);
      check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("abort_req_ready", 32'(bus.req_ready), 32'd1);
      repeat (3) @(negedge clk);
      check("abort_resp_valid_later", 32'(bus.resp_valid), 32'd0);
      @(posedge clk);
      #1;
      xact(0, 2'd2, 0, 32'h20, 32'h0, 32'h11223344, 0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
